// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcode encoding and the
// hardwired-zero register index. Imported by the operand fetch stage files.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_N  = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_t;

  localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;

  // True when the index names a writable (non-R0) register.
  function automatic logic is_live_reg(input logic [ADDR_W-1:0] addr);
    return (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 8 x 16-bit register file: two combinational read ports, one synchronous
// write port, asynchronous active-low clear. R0 always reads zero and is
// never written.
module regfile_2r1w
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_mem [REG_N];

  // Register storage: cleared on reset, written when a live register is targeted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_N; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (i_wen && is_live_reg(i_waddr)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read ports: R0 is forced to zero regardless of storage contents.
  always_comb begin
    o_rdata1 = {DATA_W{1'b0}};
    o_rdata2 = {DATA_W{1'b0}};
    if (is_live_reg(i_raddr1)) begin
      o_rdata1 = r_mem[i_raddr1];
    end else begin
      o_rdata1 = {DATA_W{1'b0}};
    end
    if (is_live_reg(i_raddr2)) begin
      o_rdata2 = r_mem[i_raddr2];
    end else begin
      o_rdata2 = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage ahead of the 16-bit ALU. Reads two source registers,
// registers a/b/op/rd toward the ALU behind a valid/ready handshake with no
// skid buffer, and absorbs writebacks from downstream.
// Build option: define OPERAND_FWD_EN for write-first bypass of a same-cycle
// writeback into the operands being accepted; otherwise reads are read-first.
module operand_fetch_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_op,
  output logic [ADDR_W-1:0] out_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_a;
  logic [DATA_W-1:0] r_out_b;
  alu_op_t           r_out_op;
  logic [ADDR_W-1:0] r_out_rd;

  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic              w_in_ready;
  logic              w_accept;

  regfile_2r1w u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_raddr1 (in_rs1),
    .i_raddr2 (in_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2),
    .i_wen    (wb_en),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data)
  );

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  // Operand select: register-file value, optionally replaced by a same-cycle writeback.
  always_comb begin
    w_opa = w_rdata1;
    w_opb = w_rdata2;
`ifdef OPERAND_FWD_EN
    if (wb_en && is_live_reg(in_rs1) && (wb_addr == in_rs1)) begin
      w_opa = wb_data;
    end else begin
      w_opa = w_rdata1;
    end
    if (wb_en && is_live_reg(in_rs2) && (wb_addr == in_rs2)) begin
      w_opb = wb_data;
    end else begin
      w_opb = w_rdata2;
    end
`else
    w_opa = w_rdata1;
    w_opb = w_rdata2;
`endif
  end

  // Output handshake register: load on accept, drop valid on drain, hold while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_a     <= {DATA_W{1'b0}};
      r_out_b     <= {DATA_W{1'b0}};
      r_out_op    <= ALU_ADD;
      r_out_rd    <= REG_ZERO;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_a     <= w_opa;
      r_out_b     <= w_opb;
      r_out_op    <= alu_op_t'(in_op);
      r_out_rd    <= in_rd;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_a     = r_out_a;
  assign out_b     = r_out_b;
  assign out_op    = r_out_op;
  assign out_rd    = r_out_rd;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed vector table,
// hand-written stall / back-to-back / reset-mid-stall sequences, then
// random traffic against an array-based reference model.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rs1;
  logic [2:0]  in_rs2;
  logic [2:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [2:0]  out_op;
  logic [2:0]  out_rd;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  operand_fetch_stage dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op),
    .out_rd    (out_rd),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

`ifdef OPERAND_FWD_EN
  localparam logic [15:0] BYP_A = 16'hFFBF;
`else
  localparam logic [15:0] BYP_A = 16'h0000;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] m_regs [8];
  logic        m_valid;
  logic [15:0] m_a, m_b;
  logic [2:0]  m_op, m_rd;
  logic        mdl_rdy, act_rdy;

  typedef struct {
    logic        wen;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        iv;
    logic [2:0]  op, rs1, rs2, rd;
    logic        ordy;
    logic        e_rdy;
    logic        e_v;
    logic [15:0] e_a, e_b;
    logic [2:0]  e_op, e_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_valid = 1'b0; m_a = 16'h0000; m_b = 16'h0000; m_op = 3'd0; m_rd = 3'd0;
  endtask

  function automatic logic [15:0] mdl_read(input logic [2:0] rs);
    if (rs == 3'd0) return 16'h0000;
`ifdef OPERAND_FWD_EN
    if (wb_en && wb_addr == rs) return wb_data;
`endif
    return m_regs[rs];
  endfunction

  task automatic set_in(input logic wen, input logic [2:0] wa, input logic [15:0] wd,
                        input logic iv, input logic [2:0] op, input logic [2:0] r1,
                        input logic [2:0] r2, input logic [2:0] rd, input logic ordy);
    wb_en = wen; wb_addr = wa; wb_data = wd;
    in_valid = iv; in_op = op; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    out_ready = ordy;
  endtask

  // One clock: sample in_ready, advance model, cross the edge, settle.
  task automatic tick();
    logic acc;
    #1;
    act_rdy = in_ready;
    mdl_rdy = !m_valid || out_ready;
    acc = in_valid && mdl_rdy;
    if (acc) begin
      m_a = mdl_read(in_rs1); m_b = mdl_read(in_rs2);
      m_op = in_op; m_rd = in_rd; m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_en && wb_addr != 3'd0) m_regs[wb_addr] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_in_ready"}, {31'd0, act_rdy}, {31'd0, mdl_rdy});
    chk({nm, "_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    chk({nm, "_a"}, {16'd0, out_a}, {16'd0, m_a});
    chk({nm, "_b"}, {16'd0, out_b}, {16'd0, m_b});
    chk({nm, "_op"}, {29'd0, out_op}, {29'd0, m_op});
    chk({nm, "_rd"}, {29'd0, out_rd}, {29'd0, m_rd});
  endtask

  initial begin
    // wen waddr wdata iv op rs1 rs2 rd ordy | e_rdy e_v e_a e_b e_op e_rd
    vecs[0] = '{1'b1, 3'd1, 16'hAAAA, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1,
                1'b1, 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd0};
    vecs[1] = '{1'b1, 3'd2, 16'h5555, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1,
                1'b1, 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd0};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd1, 3'd2, 3'd3, 1'b1,
                1'b1, 1'b1, 16'hAAAA, 16'h5555, 3'd4, 3'd3};
    vecs[3] = '{1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1,
                1'b1, 1'b0, 16'hAAAA, 16'h5555, 3'd4, 3'd3};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, 3'd0, 3'd5, 1'b1,
                1'b1, 1'b1, 16'h0000, 16'h0000, 3'd0, 3'd5};
    vecs[5] = '{1'b1, 3'd4, 16'hFFBF, 1'b1, 3'd2, 3'd4, 3'd1, 3'd6, 1'b1,
                1'b1, 1'b1, BYP_A, 16'hAAAA, 3'd2, 3'd6};
    vecs[6] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1,
                1'b1, 1'b0, BYP_A, 16'hAAAA, 3'd2, 3'd6};
    vecs[7] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd4, 3'd4, 3'd7, 1'b1,
                1'b1, 1'b1, 16'hFFBF, 16'hFFBF, 3'd3, 3'd7};
    vecs[8] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1,
                1'b1, 1'b0, 16'hFFBF, 16'hFFBF, 3'd3, 3'd7};

    // Reset
    reset_n = 1'b0;
    set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_a", {16'd0, out_a}, 32'd0);
    chk("reset_b", {16'd0, out_b}, 32'd0);
    chk("reset_op_rd", {26'd0, out_op, out_rd}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].iv, vecs[i].op,
             vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].ordy);
      tick();
      chk($sformatf("vec%0d_in_ready", i), {31'd0, act_rdy}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_v});
      chk($sformatf("vec%0d_a", i), {16'd0, out_a}, {16'd0, vecs[i].e_a});
      chk($sformatf("vec%0d_b", i), {16'd0, out_b}, {16'd0, vecs[i].e_b});
      chk($sformatf("vec%0d_op", i), {29'd0, out_op}, {29'd0, vecs[i].e_op});
      chk($sformatf("vec%0d_rd", i), {29'd0, out_rd}, {29'd0, vecs[i].e_rd});
    end

    // Stall: A accepted with ALU not ready, then B waits three cycles
    set_in(1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd1, 3'd2, 3'd1, 1'b0);
    tick();
    chk_model("stall_load");
    set_in(1'b1, 3'd1, 16'h1234, 1'b1, 3'd6, 3'd4, 3'd2, 3'd2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_in_ready", {31'd0, act_rdy}, 32'd0);
      chk("stall_hold_a", {16'd0, out_a}, 32'h0000AAAA);
      chk("stall_hold_b", {16'd0, out_b}, 32'h00005555);
      chk("stall_hold_rd", {29'd0, out_rd}, 32'd1);
      chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      if (k == 0) set_in(1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd4, 3'd2, 3'd2, 1'b0);
    end
    set_in(1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd4, 3'd2, 3'd2, 1'b1);
    tick();
    chk("stall_release_rd", {29'd0, out_rd}, 32'd2);
    chk("stall_release_a", {16'd0, out_a}, 32'h0000FFBF);
    chk("stall_release_op", {29'd0, out_op}, 32'd6);
    chk_model("stall_release");
    set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    tick();
    chk("stall_no_dup", {31'd0, out_valid}, 32'd0);

    // Back-to-back: four instructions, one per cycle, in order
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 3'd0, 16'h0000, 1'b1, 3'(k), 3'(k + 1), 3'd0, 3'(k + 4), 1'b1);
      tick();
      chk($sformatf("b2b%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("b2b%0d_rd", k), {29'd0, out_rd}, 32'(k + 4));
      chk_model($sformatf("b2b%0d", k));
    end
    set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    tick();
    chk("b2b_end_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-stall
    set_in(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd1, 3'd2, 3'd3, 1'b0);
    tick();
    chk("rst_stall_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_stall_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall_async_a", {16'd0, out_a}, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int r = 1; r < 8; r += 2) begin
      set_in(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'(r), 3'(r + 1), 3'd1, 1'b1);
      tick();
      chk($sformatf("rst_clear_r%0d", r), {16'd0, out_a}, 32'd0);
      chk($sformatf("rst_clear_r%0d", r + 1), {16'd0, out_b}, 32'd0);
    end

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      tick();
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
